// File: rtl/fxp_sqrt_iter.sv
// Iterative restoring square root for unsigned Q(WIDTH-FRAC_WIDTH).FRAC_WIDTH operands,
// resolving BITS_PER_CYCLE root bits per clock behind valid/ready handshakes.
module fxp_sqrt_iter #(
  parameter int WIDTH          = 32,
  parameter int FRAC_WIDTH     = 30,
  parameter int BITS_PER_CYCLE = 1,
  parameter int ROUND          = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             exact,
  output logic             busy
);

  localparam int VW    = WIDTH + FRAC_WIDTH;
  localparam int NB    = (VW + 1) / 2;
  localparam int N     = ((NB + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE) * BITS_PER_CYCLE;
  localparam int TWO_N = 2 * N;
  localparam int ITER  = N / BITS_PER_CYCLE;
  localparam int CW    = $clog2(ITER + 1);
  localparam int RW    = N + WIDTH + 2;
  localparam logic [RW-1:0] SAT = {{(RW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [TWO_N-1:0]   v_q;
  logic [N-1:0]       root_q;
  logic [N:0]         rem_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   out_q;
  logic               exact_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [TWO_N-1:0]   v_d;
  logic [N-1:0]       root_d;
  logic [N:0]         rem_d;
  logic [WIDTH-1:0]   res_d;
  logic               exact_d;
  logic [TWO_N-1:0]   v_init;
  logic [N+1:0]       rem_w;
  logic [N+1:0]       trial;
  logic [RW-1:0]      root_ext;
  logic [RW-1:0]      rem_ext;
  logic [RW-1:0]      rounded;

  assign v_init    = TWO_N'(num_in) << FRAC_WIDTH;
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign exact     = exact_q;
  assign busy      = busy_q;

  // One iteration of the restoring recurrence, unrolled BITS_PER_CYCLE times.
  // Before the last root bit the partial remainder never exceeds N bits, so the
  // top bits dropped by the 2-bit shift are always zero.
  always_comb begin
    v_d    = v_q;
    root_d = root_q;
    rem_w  = {1'b0, rem_q};
    trial  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_w = {rem_w[N-1:0], v_d[TWO_N-1 -: 2]};
      trial = {root_d, 2'b01};
      if (rem_w >= trial) begin
        rem_w  = rem_w - trial;
        root_d = (root_d << 1) | N'(1'b1);
      end else begin
        root_d = root_d << 1;
      end
      v_d = v_d << 2;
    end
    rem_d = rem_w[N:0];
  end

  // Result formatting: optional round-half-up (REM > R) with saturation.
  always_comb begin
    root_ext = RW'(root_d);
    rem_ext  = RW'(rem_d);
    exact_d  = (rem_d == '0);
    if ((ROUND != 0) && (rem_ext > root_ext)) begin
      rounded = root_ext + RW'(1'b1);
    end else begin
      rounded = root_ext;
    end
    if (rounded > SAT) begin
      res_d = {WIDTH{1'b1}};
    end else begin
      res_d = rounded[WIDTH-1:0];
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      v_q         <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      exact_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            v_q     <= v_init;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= CW'(ITER);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          v_q    <= v_d;
          root_q <= root_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q - CW'(1'b1);
          if (cnt_q == CW'(1'b1)) begin
            out_q       <= res_d;
            exact_q     <= exact_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              v_q     <= v_init;
              root_q  <= '0;
              rem_q   <= '0;
              cnt_q   <= CW'(ITER);
              busy_q  <= 1'b1;
              state_q <= CALC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
